// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle MIPS state register and datapath strobe decoder.
// Define CTRL_PERF_CNT_EN to build the cycle/retired-instruction counters.
`ifndef STATE_LEN
`define STATE_LEN 3
`endif
`ifndef STATE_IF
`define STATE_IF 0
`endif
`ifndef STATE_ID
`define STATE_ID 1
`endif
`ifndef STATE_EX
`define STATE_EX 2
`endif
`ifndef STATE_MEM
`define STATE_MEM 3
`endif
`ifndef STATE_WB
`define STATE_WB 4
`endif
module control_sequencer #(
  parameter int STATE_LEN  = `STATE_LEN,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            opcode,
  input  logic [STATE_LEN-1:0]  new_state,
  input  logic                  mem_ready,
  input  logic                  alu_zero,
  output logic                  fsm_rst,
  output logic [STATE_LEN-1:0]  state,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  ir_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  iord,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  retire,
  output logic [PERF_CNT_W-1:0] cycle_cnt,
  output logic [PERF_CNT_W-1:0] instr_cnt
);
  localparam logic [STATE_LEN-1:0] S_IF  = STATE_LEN'(`STATE_IF);
  localparam logic [STATE_LEN-1:0] S_ID  = STATE_LEN'(`STATE_ID);
  localparam logic [STATE_LEN-1:0] S_EX  = STATE_LEN'(`STATE_EX);
  localparam logic [STATE_LEN-1:0] S_MEM = STATE_LEN'(`STATE_MEM);
  localparam logic [STATE_LEN-1:0] S_WB  = STATE_LEN'(`STATE_WB);
  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;
  logic is_if, is_id, is_ex, is_mem, is_wb, valid, is_lw, is_sw, is_j, is_beq, stall;
  always_comb begin
    is_if  = state == S_IF;
    is_id  = state == S_ID;
    is_ex  = state == S_EX;
    is_mem = state == S_MEM;
    is_wb  = state == S_WB;
    valid  = is_if || is_id || is_ex || is_mem || is_wb;
    is_lw  = opcode == OP_LW;
    is_sw  = opcode == OP_SW;
    is_j   = opcode == OP_J;
    is_beq = opcode == OP_BEQ;
    stall  = !mem_ready && (is_if || (is_mem && (is_lw || is_sw)));
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= S_IF;
    else if (!valid) state <= S_IF;
    else if (!stall) state <= new_state;
  // Every strobe is qualified by rst_n so a reset drops an in-flight access in the same cycle.
  always_comb begin
    fsm_rst    = !rst_n;
    pc_write   = rst_n && ((is_if && mem_ready) || (is_id && is_j) || (is_ex && is_beq && alu_zero));
    pc_src     = !rst_n ? 2'd0 : (is_id && is_j) ? 2'd2 : (is_ex && is_beq) ? 2'd1 : 2'd0;
    ir_write   = rst_n && is_if && mem_ready;
    mem_read   = rst_n && (is_if || (is_mem && is_lw));
    mem_write  = rst_n && is_mem && is_sw;
    iord       = rst_n && is_mem && (is_lw || is_sw);
    reg_write  = rst_n && is_wb;
    reg_dst    = rst_n && is_wb && opcode == OP_R;
    mem_to_reg = rst_n && is_wb && is_lw;
    retire     = rst_n && !stall && !is_if && new_state == S_IF;
  end
`ifdef CTRL_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] cyc_q, ins_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      if (retire) ins_q <= ins_q + 1'b1;
    end
  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif
endmodule
